dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: posts aligned stores into a write buffer, drains it to memory,
// and services loads only once the buffer is empty so reads observe earlier writes.
module dmem_responder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [3:0]  cpu_we_i,
    input  logic        cpu_re_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    output logic        misaligned_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        READ,
        RESP
    } state_t;

    state_t state;

    logic [29:0] buf_addr [DEPTH];
    logic [3:0]  buf_be   [DEPTH];
    logic [31:0] buf_data [DEPTH];

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic [1:0]  off;
    logic [3:0]  lane_be;
    logic [31:0] lane_data;
    logic        is_store;
    logic        is_load;
    logic        misaligned;
    logic        store_req;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;

    always_comb begin
        off        = cpu_addr_i[1:0];
        lane_be    = cpu_we_i << off;
        lane_data  = cpu_wdata_i << {off, 3'b000};
        is_store   = (cpu_we_i != 4'b0000);
        misaligned = ((cpu_we_i == 4'b0011) && (off == 2'd3)) ||
                     ((cpu_we_i == 4'b1111) && (off != 2'd0));
        store_req  = is_store && !misaligned;
        // a store in the same cycle wins; the load is ignored
        is_load    = cpu_re_i && !is_store;
        full       = (count == CNT_W'(DEPTH));
        empty      = (count == '0);
        pop        = (state == DRAIN) && mem_req_o && mem_ack_i;
        push       = rst_n && store_req && (!full || pop);

        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        misaligned_o = rst_n && is_store && misaligned;
        cpu_stall_o  = rst_n && ((store_req && full && !pop) ||
                                 (is_load && (state != RESP)));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wptr] <= cpu_addr_i[31:2];
            buf_be[wptr]   <= lane_be;
            buf_data[wptr] <= lane_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            cpu_rdata_o <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!empty) begin
                        state       <= DRAIN;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= buf_addr[rptr];
                        mem_be_o    <= buf_be[rptr];
                        mem_wdata_o <= buf_data[rptr];
                    end else if (is_load) begin
                        state       <= READ;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= cpu_addr_i[31:2];
                        mem_be_o    <= 4'b1111;
                        mem_wdata_o <= '0;
                    end
                end

                DRAIN: begin
                    // mem_req_o low inside DRAIN is the idle gap between two writes
                    if (mem_req_o) begin
                        if (mem_ack_i) begin
                            mem_req_o <= 1'b0;
                            mem_we_o  <= 1'b0;
                            if (count_next == '0) begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= buf_addr[rptr];
                        mem_be_o    <= buf_be[rptr];
                        mem_wdata_o <= buf_data[rptr];
                    end
                end

                READ: begin
                    if (mem_ack_i) begin
                        cpu_rdata_o <= mem_rdata_i;
                        mem_req_o   <= 1'b0;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
